// File: rtl/spi_shift_engine_if.sv
// rtl/spi_shift_engine_if.sv - SPI shift engine control, status and pad signal bundle
// SPI_SHIFT_LSB_FIRST_EN adds the lsb_first control.
interface spi_shift_engine_if #(parameter int DATA_W = 8);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              ckp;
    logic              cke;
`ifdef SPI_SHIFT_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

`ifdef SPI_SHIFT_LSB_FIRST_EN
    modport master (output start, tx_data, ckp, cke, lsb_first, miso,
                    input  sclk, mosi, busy, done, rx_data);
    modport slave  (input  start, tx_data, ckp, cke, lsb_first, miso,
                    output sclk, mosi, busy, done, rx_data);
`else
    modport master (output start, tx_data, ckp, cke, miso,
                    input  sclk, mosi, busy, done, rx_data);
    modport slave  (input  start, tx_data, ckp, cke, miso,
                    output sclk, mosi, busy, done, rx_data);
`endif
endinterface

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master shift engine, all four ckp/cke modes, single clock domain
// SPI_SHIFT_LSB_FIRST_EN enables the lsb_first bit-order select.
module spi_shift_engine #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input logic               RW_clock,
    input logic               rst,
    spi_shift_engine_if.slave bus
);
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              ckp_q, ckp_d;
    logic              cke_q, cke_d;
    logic              lsb_q, lsb_d;
    logic              lsb_in;

`ifdef SPI_SHIFT_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    logic half_end;
    logic last_edge;
    logic leading;
    logic sample_now;
    logic drive_now;

    assign half_end   = (cnt_q == CNT_W'(DIV - 1));
    assign last_edge  = (edge_q == EDGE_W'(2 * DATA_W - 1));
    // edge_q counts completed toggles, so an even count means the next toggle is leading
    assign leading    = ~edge_q[0];
    assign sample_now = cke_q ? ~leading : leading;
    assign drive_now  = cke_q ? leading : (~leading & ~last_edge);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        ckp_d     = ckp_q;
        cke_d     = cke_q;
        lsb_d     = lsb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_sr_d = '0;
                    sclk_d  = bus.ckp;
                    ckp_d   = bus.ckp;
                    cke_d   = bus.cke;
                    lsb_d   = lsb_in;
                    if (!bus.cke) begin
                        mosi_d  = lsb_in ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
                        tx_sr_d = lsb_in ? (bus.tx_data >> 1) : (bus.tx_data << 1);
                    end else begin
                        tx_sr_d = bus.tx_data;
                    end
                end
            end
            ST_SHIFT: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (sample_now) begin
                        rx_sr_d = lsb_q ? {bus.miso, rx_sr_q[DATA_W-1:1]}
                                        : {rx_sr_q[DATA_W-2:0], bus.miso};
                    end
                    if (drive_now) begin
                        mosi_d  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
                        tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                    end
                    if (last_edge) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (half_end) begin
                    cnt_d     = '0;
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge RW_clock) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            ckp_q     <= 1'b0;
            cke_q     <= 1'b0;
            lsb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            ckp_q     <= ckp_d;
            cke_q     <= cke_d;
            lsb_q     <= lsb_d;
        end
    end

    // Idle sclk follows the live polarity input so a mode change is visible before start
    assign bus.sclk    = (state_q == ST_IDLE) ? bus.ckp : sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - randomized self-checking bench for spi_shift_engine against an SPI slave model
module tb_spi_shift_engine;
    localparam int W   = 8;
    localparam int DV  = 2;
    localparam int LAT = (2 * W + 1) * DV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_shift_engine_if #(.DATA_W(W)) bus ();
    spi_shift_engine #(.DATA_W(W), .DIV(DV)) dut (.RW_clock(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    int         miso_mode = 0;
    logic       slave_bit = 1'b0;
    logic       m_cke, m_lsb, m_prev_sclk, m_prev_mosi, m_prev_busy;
    logic [W-1:0] m_word, m_cap;
    int         m_edges, m_rises, m_cap_idx, m_slave_idx, m_viol;
    int         done_cnt = 0;

    assign bus.miso = (miso_mode == 1) ? bus.mosi : (miso_mode == 2) ? 1'b1 : slave_bit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic slave_bit_at(input int idx);
        if (idx < 0 || idx >= W) return 1'b0;
        return m_lsb ? m_word[idx] : m_word[W-1-idx];
    endfunction

    // Slave side: counts sclk edges, captures mosi on sample edges, drives miso on shift edges
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.busy) begin
            if (bus.sclk !== m_prev_sclk) begin
                logic lead;
                m_edges++;
                lead = (m_edges % 2) == 1;
                if (bus.sclk) m_rises++;
                if ((m_cke ? !lead : lead) && m_cap_idx < W) begin
                    if (m_lsb) m_cap[m_cap_idx] = bus.mosi;
                    else       m_cap[W-1-m_cap_idx] = bus.mosi;
                    m_cap_idx++;
                end
                if (m_cke ? lead : !lead) begin
                    m_slave_idx++;
                    slave_bit = slave_bit_at(m_slave_idx);
                end
                if (bus.mosi !== m_prev_mosi && !(m_cke ? lead : !lead)) m_viol++;
            end else if (m_prev_busy && bus.mosi !== m_prev_mosi) begin
                m_viol++;
            end
        end
        m_prev_sclk = bus.sclk;
        m_prev_mosi = bus.mosi;
        m_prev_busy = bus.busy;
    end

    task automatic set_lsb(input logic v);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        bus.lsb_first = v;
`endif
        m_lsb = v;
    endtask

    task automatic begin_xfer(input logic [W-1:0] tx, input logic ckp_i, input logic cke_i,
                              input logic lsb_i, input int mode_i, input logic [W-1:0] sw);
        @(posedge clk); #1;
        m_cke = cke_i; m_word = sw; m_edges = 0; m_rises = 0; m_cap = '0;
        m_cap_idx = 0; m_viol = 0;
        set_lsb(lsb_i);
        m_slave_idx = cke_i ? -1 : 0;
        slave_bit = slave_bit_at(m_slave_idx);
        miso_mode = mode_i;
        bus.tx_data = tx; bus.ckp = ckp_i; bus.cke = cke_i; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_xfer(input logic [W-1:0] tx, input logic ckp_i, input logic cke_i,
                            input logic lsb_i, input int mode_i, input logic [W-1:0] sw,
                            input bit inject, input bit restart_on_done);
        logic [W-1:0] exp_rx;
        int k, busy_n, d0;
        exp_rx = (mode_i == 1) ? tx : (mode_i == 2) ? {W{1'b1}} : sw;
        d0 = done_cnt;
        begin_xfer(tx, ckp_i, cke_i, lsb_i, mode_i, sw);
        k = 0; busy_n = 0;
        while (!bus.done && k < 2000) begin
            if (bus.busy) busy_n++;
            if (inject && k == 10) begin
                bus.start = 1'b1; bus.tx_data = ~tx; bus.ckp = ~ckp_i; bus.cke = ~cke_i;
            end
            if (inject && k == 12) begin
                bus.start = 1'b0; bus.ckp = ckp_i; bus.cke = cke_i;
            end
            @(posedge clk); #1;
            k++;
        end
        check_eq("done_latency", k, LAT);
        check_eq("busy_cycles", busy_n, LAT);
        check_eq("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
        check_eq("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_rx});
        check_eq("mosi_word", {24'd0, m_cap}, {24'd0, tx});
        check_eq("sclk_edges", m_edges, 2 * W);
        check_eq("sclk_rises", m_rises, W);
        check_eq("mosi_timing", m_viol, 0);
        check_eq("sclk_idle", {31'd0, bus.sclk}, {31'd0, ckp_i});
        if (restart_on_done) begin
            bus.start = 1'b1; bus.tx_data = ~tx;
        end
        @(posedge clk); #1;
        check_eq("done_one_cycle", {31'd0, bus.done}, 32'd0);
        if (restart_on_done) check_eq("start_on_done_ignored", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        check_eq("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int g, d0;
        logic lsb_r;
        rst = 1'b1;
        bus.start = 1'b0; bus.tx_data = '0; bus.ckp = 1'b1; bus.cke = 1'b0;
        set_lsb(1'b0);
        m_cke = 1'b0; m_word = '0; m_cap = '0; m_edges = 0; m_rises = 0;
        m_cap_idx = 0; m_slave_idx = 0; m_viol = 0;
        m_prev_sclk = 1'b1; m_prev_mosi = 1'b0; m_prev_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_mosi", {31'd0, bus.mosi}, 32'd0);
        check_eq("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check_eq("rst_sclk_ckp1", {31'd0, bus.sclk}, 32'd1);
        bus.ckp = 1'b0;
        #1;
        check_eq("rst_sclk_ckp0", {31'd0, bus.sclk}, 32'd0);
        rst = 1'b0;

        // Abort after the 7th sclk edge: no done, outputs back to reset values
        d0 = done_cnt;
        begin_xfer(8'hC3, 1'b1, 1'b0, 1'b0, 0, 8'h3C);
        g = 0;
        while (m_edges < 7 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("abort_reach_edge7", m_edges, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_sclk", {31'd0, bus.sclk}, 32'd1);
        check_eq("abort_mosi", {31'd0, bus.mosi}, 32'd0);
        check_eq("abort_rx_data", {24'd0, bus.rx_data}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_stays_idle", {31'd0, bus.busy}, 32'd0);

        run_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0);
        run_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_xfer(8'h71, 1'b0, 1'b1, 1'b0, 0, 8'h96, 1'b0, 1'b0);
        run_xfer(8'hE8, 1'b1, 1'b0, 1'b0, 0, 8'h5A, 1'b0, 1'b1);
        run_xfer(8'h42, 1'b0, 1'b0, 1'b0, 0, 8'h81, 1'b1, 1'b0);
        run_xfer(8'h80, 1'b1, 1'b1, 1'b0, 1, 8'h00, 1'b1, 1'b1);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        run_xfer(8'h01, 1'b0, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0);
        run_xfer(8'hB4, 1'b1, 1'b1, 1'b1, 0, 8'h2D, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef SPI_SHIFT_LSB_FIRST_EN
            lsb_r = 1'($urandom_range(0, 1));
`else
            lsb_r = 1'b0;
`endif
            run_xfer(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lsb_r,
                     int'($urandom_range(0, 2)), W'($urandom),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
